// File: rtl/pipo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipo_arb_pkg
// Purpose  : Shared types and constants for the PIPO load arbiter: state
//            encoding, default parameter values and the owner-index width.
// Revision : 1.0 - initial release
// ============================================================================
package pipo_arb_pkg;

    localparam int C_WIDTH_DEFAULT   = 4;
    localparam int C_N_REQ_DEFAULT   = 2;
    localparam int C_TIMEOUT_DEFAULT = 8;

    // Register empty (IDLE) or holding unconsumed data (HOLD)
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // Bits needed to index one of n requesters (never less than one bit)
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pipo_arb_pkg
`default_nettype wire

// File: rtl/pipo_load_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipo_load_reg
// Purpose  : WIDTH-bit parallel-in/parallel-out register with load enable and
//            asynchronous active-high clear.
// Revision : 1.0 - initial release
// ============================================================================
module pipo_load_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Capture d when load is asserted, otherwise keep the held value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : pipo_load_reg
`default_nettype wire

// File: rtl/pipo_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pipo_load_arbiter
// Purpose  : Round-robin arbiter that loads the winning requester's data into
//            a shared PIPO register and holds it until the consumer accepts
//            it (1-entry buffer, back-to-back reload with no bubble).
// Options  : PIPO_ARB_TIMEOUT_EN - force release of data held for TIMEOUT
//            consecutive not-ready cycles and pulse 'timeout'.
// Revision : 1.0 - initial release
// ============================================================================
module pipo_load_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int WIDTH   = C_WIDTH_DEFAULT,
    parameter int N_REQ   = C_N_REQ_DEFAULT,
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic [$clog2(N_REQ)-1:0] q_owner,
    output logic                     timeout
);

    localparam int OW = owner_width(N_REQ);

    arb_state_t       r_state;
    logic [OW-1:0]    r_ptr;
    logic [OW-1:0]    r_owner;

    logic             w_window;
    logic             w_found;
    logic [OW-1:0]    w_win;
    logic             w_load;
    logic [OW-1:0]    w_ptr_next;
    logic [WIDTH-1:0] w_load_data;

    // Grant window is open when empty, or when the consumer takes q this cycle
    assign w_window = (r_state == ARB_IDLE) || q_ready;

    // Round-robin search: first valid requester starting at the pointer
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_win   = OW'(v_idx);
            end
        end
    end

    assign w_load      = w_window && w_found;
    assign w_ptr_next  = (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
    assign w_load_data = req_data[int'(w_win)*WIDTH +: WIDTH];

    // One-hot grant; reset kills it immediately, independent of the clock
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = !reset && w_load && (int'(w_win) == i);
        end
    end

`ifdef PIPO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // Arbiter FSM with hold-time watchdog; a timed-out hold never overlaps a
    // grant because q_ready is low whenever the watchdog is counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_load) begin
                r_state <= ARB_HOLD;
                r_owner <= w_win;
                r_ptr   <= w_ptr_next;
                r_cnt   <= '0;
            end else if (r_state == ARB_HOLD && q_ready) begin
                r_state <= ARB_IDLE;
                r_cnt   <= '0;
            end else if (r_state == ARB_HOLD) begin
                if (int'(r_cnt) == TIMEOUT - 1) begin
                    r_state   <= ARB_IDLE;
                    r_timeout <= 1'b1;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign timeout = r_timeout;
`else
    // Arbiter FSM: load on grant, release on consume with no new request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            if (w_load) begin
                r_state <= ARB_HOLD;
                r_owner <= w_win;
                r_ptr   <= w_ptr_next;
            end else if (r_state == ARB_HOLD && q_ready) begin
                r_state <= ARB_IDLE;
            end
        end
    end

    assign timeout = 1'b0;
`endif

    assign q_valid = (r_state == ARB_HOLD);
    assign q_owner = r_owner;

    pipo_load_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .d     (w_load_data),
        .q     (q)
    );

endmodule : pipo_load_arbiter
`default_nettype wire

// File: tb/tb_pipo_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipo_load_arbiter
// Purpose  : Self-checking bench for pipo_load_arbiter: directed scenarios
//            with literal expectations plus randomized traffic compared every
//            cycle against a behavioural model.
// Options  : PIPO_ARB_TIMEOUT_EN selects the forced-release expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipo_load_arbiter;

    localparam int W  = 4;
    localparam int N  = 2;
    localparam int TO = 8;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     q;
    logic             q_valid;
    logic             q_ready;
    logic [$clog2(N)-1:0] q_owner;
    logic             timeout;

    int n_tests = 0;
    int n_fail  = 0;

    pipo_load_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_owner   (q_owner),
        .timeout   (timeout)
    );

    // First rising edge at 7 ns, period 10 ns
    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_hold  = 0;
    int         m_ptr   = 0;
    int         m_owner = 0;
    int         m_cnt   = 0;
    int         m_to    = 0;
    logic [W-1:0] m_q   = '0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        if (!reset && (m_hold == 0 || q_ready)) begin
            w = pick(req_valid, m_ptr);
            if (w >= 0) r[w] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        int w;
        if (reset) begin
            m_hold = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_to = 0; m_q = '0;
        end else begin
            m_to = 0;
            w = (m_hold == 0 || q_ready) ? pick(req_valid, m_ptr) : -1;
            if (w >= 0) begin
                m_q     = req_data[w*W +: W];
                m_owner = w;
                m_hold  = 1;
                m_ptr   = (w + 1) % N;
                m_cnt   = 0;
            end else if (m_hold != 0 && q_ready) begin
                m_hold = 0;
                m_cnt  = 0;
            end
`ifdef PIPO_ARB_TIMEOUT_EN
            else if (m_hold != 0) begin
                m_cnt++;
                if (m_cnt == TO) begin
                    m_hold = 0;
                    m_to   = 1;
                    m_cnt  = 0;
                end
            end
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("cmp_req_ready", 32'(req_ready), 32'(exp_ready()));
        chk("cmp_q",         32'(q),         32'(m_q));
        chk("cmp_q_valid",   32'(q_valid),   32'(m_hold));
        chk("cmp_q_owner",   32'(q_owner),   32'(m_owner));
        chk("cmp_timeout",   32'(timeout),   32'(m_to));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    logic [W-1:0] e2 [4];

    initial begin
        e2[0] = 4'b0100; e2[1] = 4'b1000; e2[2] = 4'b0100; e2[3] = 4'b1000;

        // 1. Reset and first grant
        reset     = 1'b1;
        req_valid = 2'b01;
        req_data  = {4'b0000, 4'b1001};
        q_ready   = 1'b1;
        #3;
        chk("t1_rst_ready", 32'(req_ready), 32'h0);
        chk("t1_rst_q",     32'(q),         32'h0);
        chk("t1_rst_qv",    32'(q_valid),   32'h0);
        #12;
        reset = 1'b0;
        #1;
        chk("t1_first_ready", 32'(req_ready), 32'b01);
        tick();
        chk("t1_q",     32'(q),       32'b1001);
        chk("t1_qv",    32'(q_valid), 32'h1);
        chk("t1_owner", 32'(q_owner), 32'h0);

        // 2. Round-robin alternation, no bubbles
        do_reset();
        req_valid = 2'b11;
        req_data  = {4'b1000, 4'b0100};
        q_ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_q",  32'(q),       32'(e2[i]));
            chk("t2_qv", 32'(q_valid), 32'h1);
        end

        // 3. Backpressure
        do_reset();
        req_valid = 2'b01;
        req_data  = {4'b0000, 4'b1100};
        q_ready   = 1'b1;
        tick();
        chk("t3_load", 32'(q), 32'b1100);
        q_ready   = 1'b0;
        req_valid = 2'b10;
        req_data  = {4'b1111, 4'b1100};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_bp_ready", 32'(req_ready), 32'h0);
            chk("t3_bp_q",     32'(q),         32'b1100);
            tick();
        end
        q_ready = 1'b1;
        #1;
        chk("t3_ready", 32'(req_ready), 32'b10);
        tick();
        chk("t3_q",     32'(q),       32'b1111);
        chk("t3_owner", 32'(q_owner), 32'h1);

        // 4. Release to IDLE keeps q and pointer
        req_valid = 2'b00;
        tick();
        chk("t4_qv", 32'(q_valid), 32'h0);
        chk("t4_q",  32'(q),       32'b1111);
        req_valid = 2'b11;
        req_data  = {4'b1111, 4'b1111};
        #1;
        chk("t4_ready", 32'(req_ready), 32'b01);
        tick();
        chk("t4_owner", 32'(q_owner), 32'h0);

        // 5. Asynchronous reset mid-HOLD
        q_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_q",     32'(q),         32'h0);
        chk("t5_qv",    32'(q_valid),   32'h0);
        chk("t5_ready", 32'(req_ready), 32'h0);
        reset   = 1'b0;
        q_ready = 1'b1;
        #1;
        chk("t5_after_ready", 32'(req_ready), 32'b01);
        tick();
        chk("t5_after_owner", 32'(q_owner), 32'h0);

        // 6. Hold under sustained backpressure
        do_reset();
        req_valid = 2'b01;
        req_data  = {4'b0000, 4'b0110};
        q_ready   = 1'b1;
        tick();
        req_valid = 2'b00;
        q_ready   = 1'b0;
`ifdef PIPO_ARB_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            tick();
            chk("t6_qv", 32'(q_valid), (i < TO) ? 32'h1 : 32'h0);
            chk("t6_to", 32'(timeout), (i == TO) ? 32'h1 : 32'h0);
        end
        chk("t6_q", 32'(q), 32'b0110);
        tick();
        chk("t6_to_end", 32'(timeout), 32'h0);
`else
        for (int i = 0; i < 22; i++) begin
            tick();
            chk("t6_qv", 32'(q_valid), 32'h1);
            chk("t6_to", 32'(timeout), 32'h0);
        end
        chk("t6_q", 32'(q), 32'b0110);
`endif

        // 7. Randomized traffic, checked by the per-cycle compare process
        do_reset();
        for (int i = 0; i < 500; i++) begin
            tick();
            req_valid = N'($urandom);
            req_data  = (N*W)'($urandom);
            if (i >= 200 && i < 320)
                q_ready = (($urandom % 8) == 0);
            else
                q_ready = (($urandom % 4) != 0);
            if (($urandom % 60) == 0) begin
                #1;
                reset = 1'b1;
                #5;
                reset = 1'b0;
            end
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipo_load_arbiter
`default_nettype wire

// File: doc/pipo_load_arbiter.md
Name: pipo_load_arbiter

Overview:
Shares one WIDTH-bit parallel-in/parallel-out holding register between N_REQ requesters. Arbitrates round-robin, loads the winner's data, and holds it until the downstream consumer accepts it (valid/ready), giving a 1-entry buffer with full back-to-back throughput. Sits between the requester datapaths and the register's consumer; owns the register's load enable.

Parameters:
WIDTH, 4, data width of the shared register
N_REQ, 2, number of requesters (>=2)
TIMEOUT, 8, HOLD cycles before forced release (used only with PIPO_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester request
req_data  input  N_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
req_ready  output  N_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
q  output  WIDTH  held register contents
q_valid  output  1  q holds unconsumed data
q_ready  input  1  consumer accepts q
q_owner  output  $clog2(N_REQ)  index of requester whose data is in q
timeout  output  1  one-cycle pulse on forced release (0 without macro)

Behaviour:
- Reset (asynchronous, immediate): q=0, q_valid=0, q_owner=0, rr pointer ptr=0, state=IDLE, timeout=0. req_ready is forced to all-zero while reset is high.
- States: IDLE (register empty) and HOLD (q_valid=1).
- Grant window: open when state==IDLE, or state==HOLD && q_ready. Outside the window req_ready=0.
- Winner: first i with req_valid[i]=1, searching ptr, ptr+1, ... wrapping mod N_REQ. req_ready is combinational from state, q_ready, req_valid and ptr; at most one bit is high.
- On a grant edge:
  - q <= winning req_data
  - q_owner <= winner
  - q_valid <= 1, state -> HOLD
  - ptr <= (winner+1) mod N_REQ (wraps N_REQ-1 -> 0)
- Latency: data accepted at edge k is on q after edge k (1 cycle).
- HOLD && q_ready with no valid requester: q_valid <= 0, state -> IDLE. q keeps its last value.
- HOLD && q_ready with a valid requester: reload in the same edge, so q_valid stays 1 (back-to-back, no bubble).
- HOLD && !q_ready: q, q_owner and q_valid are stable. req_ready=0.
- Requester rules: data must be stable while valid. Dropping valid before grant is legal; that requester is simply not granted.
- ptr advances only on a grant. Idle cycles do not move it.
- Reset mid-HOLD: held data is lost and all outputs return to reset values immediately.

Optional Feature:
Macro PIPO_ARB_TIMEOUT_EN.
- With the macro: a counter runs in HOLD while !q_ready and clears on any grant or release. When the counter reaches TIMEOUT:
  - q_valid <= 0, state -> IDLE
  - timeout pulses high for 1 cycle
  - q retains its value
  - a grant cannot occur in that same cycle
- Without the macro: no counter. HOLD persists indefinitely and timeout is tied 0.

Decomposition:
- Package pipo_arb_pkg holds:
  - state enum {ARB_IDLE, ARB_HOLD}
  - default WIDTH/N_REQ/TIMEOUT constants
  - owner-index width function
- One sub-module, pipo_load_reg: WIDTH-bit register with load enable and asynchronous active-high reset to 0. The arbiter drives its enable and data mux.

Test Plan:
1. Reset and first grant. Hold reset=1 for 15 ns with req_valid=01, req_data[0]=1001.
   -> req_ready=00, q=0000, q_valid=0 during reset.
   -> First edge after release: req_ready=01, then q=1001, q_valid=1, q_owner=0.
2. Round-robin. req_valid=11, data0=0100, data1=1000, q_ready=1 held.
   -> Grants alternate 0,1,0,1. q sequence is 0100, 1000, 0100, 1000 with q_valid never dropping.
3. Backpressure. Load 1100, then q_ready=0 with req1 valid carrying 1111.
   -> req_ready=00 for 5 cycles and q stays 1100.
   -> Raise q_ready: req_ready=10 that cycle, and the next edge gives q=1111, q_owner=1.
4. Release to IDLE. In HOLD, q_ready=1 and req_valid=00.
   -> q_valid=0, q holds its value, and ptr is unchanged (the next single request is granted correctly).
5. Asynchronous reset mid-HOLD. With q=1111 valid, assert reset between edges.
   -> q=0000, q_valid=0, req_ready=00 without waiting for a clock edge.
   -> After release the first grant goes to requester 0 when both are valid.
6. Timeout. With the macro and TIMEOUT=8, load 0110 and hold q_ready=0.
   -> After 8 HOLD cycles: q_valid=0, one-cycle timeout pulse, q=0110.
   -> Without the macro: q_valid stays 1 for 20+ cycles and timeout stays 0.
